// File: rtl/cpu6_memarb.sv
// cpu6_memarb -- two-requester memory bus arbiter for the cpu6 core.
//
// Shares one memory bus port between the instruction-fetch path (if_*) and
// the load/store data path (d_*). Each side uses a held req / one-cycle ack
// handshake. The grant is registered on entry to a bus state and held until
// the bus completes. Data has priority over fetch. A saturating streak
// counter forces a fetch grant after MAX_DSTREAK consecutive data grants
// taken while a fetch was waiting.
//
// Parameters:
//   MAX_DSTREAK  consecutive data grants allowed while a fetch waits (1..15)
//   TIMEOUT      bus cycles before abort (1..65535), timeout build only
//
// Optional feature macro: CPU6_MEMARB_TIMEOUT_EN
//   defined   : a 16-bit bus cycle counter aborts a stalled access with x_err=1
//   undefined : no counter; the arbiter waits for m_ack forever, errors are 0
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   if_req/if_addr               fetch request and address (in)
//   if_ack/if_rdata/if_err       fetch completion pulse, data, abort flag (out)
//   d_req/d_we/d_addr/d_wdata/d_wstrb   data request fields (in)
//   d_ack/d_rdata/d_err          data completion pulse, data, abort flag (out)
//   m_req/m_we/m_addr/m_wdata/m_wstrb   bus request fields (out, registered)
//   m_ack/m_rdata                bus completion pulse and read data (in)
//
// All outputs come straight from flops; there is no input-to-output path.

module cpu6_memarb #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUS_IF = 2'd1;
  localparam logic [1:0] S_BUS_D  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0]  DSTREAK_LIMIT = 4'(MAX_DSTREAK);
  localparam logic [15:0] TMO_LAST      = 16'(TIMEOUT - 1);

  // Elaboration-time range checks on the configuration.
  if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15) begin : g_bad_dstreak
    $error("cpu6_memarb: MAX_DSTREAK out of range 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("cpu6_memarb: TIMEOUT out of range 1..65535");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_dstreak;

  logic        r_m_req;
  logic        r_m_we;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_wstrb;

  logic        r_if_ack;
  logic [31:0] r_if_rdata;
  logic        r_if_err;
  logic        r_d_ack;
  logic [31:0] r_d_rdata;
  logic        r_d_err;

  logic        w_in_idle;
  logic        w_in_bus;
  logic        w_grant_d;
  logic        w_grant_if;
  logic        w_done;
  logic        w_tmo;

  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_bus  = (r_state == S_BUS_IF) || (r_state == S_BUS_D);

  // Data wins unless a fetch is waiting and the data streak has hit its limit.
  assign w_grant_d  = w_in_idle && d_req && !(if_req && (r_dstreak == DSTREAK_LIMIT));
  assign w_grant_if = w_in_idle && if_req && !w_grant_d;

  // A bus acknowledge always completes normally, even in a timeout cycle.
  assign w_done = w_in_bus && m_ack;

`ifdef CPU6_MEMARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // The abort fires on the bus cycle that would bring the count to TIMEOUT.
  assign w_tmo = w_in_bus && !m_ack && (r_tmo_cnt == TMO_LAST);

  // Bus cycle counter: cleared on every bus entry, counts unacknowledged cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_grant_d || w_grant_if) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_in_bus && !m_ack) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end
`else
  // Without the timeout feature no access is ever aborted.
  assign w_tmo = 1'b0;
  logic w_unused_tmo;
  assign w_unused_tmo = ^TMO_LAST;
`endif

  // Next-state logic; RESP never samples requests so a held request is not reissued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = S_BUS_D;
        end else if (w_grant_if) begin
          w_state_nxt = S_BUS_IF;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUS_IF, S_BUS_D: begin
        if (w_done || w_tmo) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data streak: counts data grants taken over a waiting fetch, saturating at 15.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dstreak <= 4'd0;
    end else if (w_grant_d) begin
      if (if_req) begin
        r_dstreak <= (r_dstreak == 4'd15) ? 4'd15 : r_dstreak + 4'd1;
      end else begin
        r_dstreak <= 4'd0;
      end
    end else if (w_grant_if) begin
      r_dstreak <= 4'd0;
    end else begin
      r_dstreak <= r_dstreak;
    end
  end

  // Bus request registers: loaded once at grant and frozen until completion,
  // so m_addr/m_wdata cannot change while m_req is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= 32'd0;
      r_m_wdata <= 32'd0;
      r_m_wstrb <= 4'd0;
    end else if (w_grant_d) begin
      r_m_req   <= 1'b1;
      r_m_we    <= d_we;
      r_m_addr  <= d_addr;
      r_m_wdata <= d_wdata;
      r_m_wstrb <= d_wstrb;
    end else if (w_grant_if) begin
      r_m_req   <= 1'b1;
      r_m_we    <= 1'b0;
      r_m_addr  <= if_addr;
      r_m_wdata <= 32'd0;
      r_m_wstrb <= 4'd0;
    end else if (w_done || w_tmo) begin
      r_m_req   <= 1'b0;
      r_m_we    <= r_m_we;
      r_m_addr  <= r_m_addr;
      r_m_wdata <= r_m_wdata;
      r_m_wstrb <= r_m_wstrb;
    end else begin
      r_m_req   <= r_m_req;
      r_m_we    <= r_m_we;
      r_m_addr  <= r_m_addr;
      r_m_wdata <= r_m_wdata;
      r_m_wstrb <= r_m_wstrb;
    end
  end

  // Fetch response: one-cycle ack in RESP; read data is held until the next fetch response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_if_ack   <= 1'b0;
      r_if_rdata <= 32'd0;
      r_if_err   <= 1'b0;
    end else if ((r_state == S_BUS_IF) && (w_done || w_tmo)) begin
      r_if_ack   <= 1'b1;
      r_if_rdata <= w_done ? m_rdata : 32'd0;
      r_if_err   <= w_tmo;
    end else begin
      r_if_ack   <= 1'b0;
      r_if_rdata <= r_if_rdata;
      r_if_err   <= 1'b0;
    end
  end

  // Data response: same shape as fetch; on a store the bus read data is kept as returned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_d_ack   <= 1'b0;
      r_d_rdata <= 32'd0;
      r_d_err   <= 1'b0;
    end else if ((r_state == S_BUS_D) && (w_done || w_tmo)) begin
      r_d_ack   <= 1'b1;
      r_d_rdata <= w_done ? m_rdata : 32'd0;
      r_d_err   <= w_tmo;
    end else begin
      r_d_ack   <= 1'b0;
      r_d_rdata <= r_d_rdata;
      r_d_err   <= 1'b0;
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_wstrb  = r_m_wstrb;
  assign if_ack   = r_if_ack;
  assign if_rdata = r_if_rdata;
  assign if_err   = r_if_err;
  assign d_ack    = r_d_ack;
  assign d_rdata  = r_d_rdata;
  assign d_err    = r_d_err;

endmodule

// File: tb/tb_cpu6_memarb.sv
// Directed testbench for cpu6_memarb. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at the same point.

module tb_cpu6_memarb;

  logic        clk;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack;
  logic [31:0] m_rdata;

  int n_cmp;
  int n_err;

  cpu6_memarb #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus acknowledge cycle carrying the given read data.
  task automatic bus_ack(input logic [31:0] rd);
    m_ack   = 1'b1;
    m_rdata = rd;
    tick();
    m_ack   = 1'b0;
    m_rdata = 32'd0;
  endtask

  logic [31:0] exp_addr;

  initial begin
    n_cmp = 0; n_err = 0;
    resetn = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
    m_ack = 1'b0; m_rdata = 32'd0;

    // Reset state
    #12;
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
    chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    resetn = 1'b1;
    tick();
    chk("rst_idle_m_req", {31'd0, m_req}, 32'd0);

    // Fetch only
    if_req = 1'b1; if_addr = 32'h0000_0100;
    tick();
    chk("f_m_req", {31'd0, m_req}, 32'd1);
    chk("f_m_addr", m_addr, 32'h0000_0100);
    chk("f_m_we", {31'd0, m_we}, 32'd0);
    chk("f_if_ack_early", {31'd0, if_ack}, 32'd0);
    bus_ack(32'h0000_0013);
    chk("f_if_ack", {31'd0, if_ack}, 32'd1);
    chk("f_if_rdata", if_rdata, 32'h0000_0013);
    chk("f_if_err", {31'd0, if_err}, 32'd0);
    chk("f_m_req_drop", {31'd0, m_req}, 32'd0);
    tick();
    chk("f_if_ack_once", {31'd0, if_ack}, 32'd0);
    chk("f_no_reissue_resp", {31'd0, m_req}, 32'd0);
    tick();
    chk("f_reissue_after_idle", {31'd0, m_req}, 32'd1);
    bus_ack(32'h0000_0093);
    if_req = 1'b0;
    chk("f2_if_rdata", if_rdata, 32'h0000_0093);
    tick();

    // Simultaneous fetch and store: data first, then fetch
    if_req = 1'b1; if_addr = 32'h0000_0104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    tick();
    chk("b_d_addr", m_addr, 32'h0000_2000);
    chk("b_d_we", {31'd0, m_we}, 32'd1);
    chk("b_d_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("b_d_wstrb", {28'd0, m_wstrb}, 32'h0000_000F);
    bus_ack(32'h0000_0055);
    d_req = 1'b0;
    chk("b_d_ack", {31'd0, d_ack}, 32'd1);
    chk("b_d_rdata_store", d_rdata, 32'h0000_0055);
    chk("b_if_ack_none", {31'd0, if_ack}, 32'd0);
    tick();
    tick();
    chk("b_if_addr", m_addr, 32'h0000_0104);
    chk("b_if_we", {31'd0, m_we}, 32'd0);
    chk("b_if_wstrb", {28'd0, m_wstrb}, 32'd0);
    bus_ack(32'h0000_0077);
    chk("b_if_ack", {31'd0, if_ack}, 32'd1);
    chk("b_if_rdata", if_rdata, 32'h0000_0077);
    tick();

    // Streak limit: both held, order D,D,D,D,IF,D,D,D,D,IF
    if_addr = 32'h0000_0300;
    d_we = 1'b0; d_addr = 32'h0000_4000; d_wdata = 32'd0; d_wstrb = 4'd0;
    d_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_addr = ((i % 5) == 4) ? 32'h0000_0300 : 32'h0000_4000;
      tick();
      chk($sformatf("streak_grant_%0d", i), m_addr, exp_addr);
      bus_ack(32'h1000_0000 + 32'(i));
      tick();
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("streak_last_if_rdata", if_rdata, 32'h1000_0009);
    chk("streak_last_d_rdata", d_rdata, 32'h1000_0008);

    // Bus with 5 wait states
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000;
    tick();
    chk("ws_m_req_c1", {31'd0, m_req}, 32'd1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk($sformatf("ws_m_req_c%0d", i), {31'd0, m_req}, 32'd1);
      chk($sformatf("ws_m_addr_c%0d", i), m_addr, 32'h0000_5000);
      chk($sformatf("ws_d_ack_c%0d", i), {31'd0, d_ack}, 32'd0);
    end
    bus_ack(32'hA5A5_0001);
    d_req = 1'b0;
    chk("ws_d_ack", {31'd0, d_ack}, 32'd1);
    chk("ws_d_rdata", d_rdata, 32'hA5A5_0001);
    chk("ws_m_req_drop", {31'd0, m_req}, 32'd0);
    tick();
    chk("ws_d_ack_once", {31'd0, d_ack}, 32'd0);

    // Stray m_ack in IDLE is ignored
    tick();
    bus_ack(32'hFFFF_FFFF);
    chk("idle_ack_d_ack", {31'd0, d_ack}, 32'd0);
    chk("idle_ack_if_ack", {31'd0, if_ack}, 32'd0);
    chk("idle_ack_m_req", {31'd0, m_req}, 32'd0);
    chk("idle_ack_d_rdata", d_rdata, 32'hA5A5_0001);

`ifdef CPU6_MEMARB_TIMEOUT_EN
    // Timeout after 8 unacknowledged bus cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_7000;
    tick();
    chk("tmo_m_req_c1", {31'd0, m_req}, 32'd1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("tmo_m_req_c%0d", i), {31'd0, m_req}, 32'd1);
      chk($sformatf("tmo_d_ack_c%0d", i), {31'd0, d_ack}, 32'd0);
    end
    tick();
    d_req = 1'b0;
    chk("tmo_d_ack", {31'd0, d_ack}, 32'd1);
    chk("tmo_d_err", {31'd0, d_err}, 32'd1);
    chk("tmo_d_rdata", d_rdata, 32'd0);
    chk("tmo_m_req", {31'd0, m_req}, 32'd0);
    tick();
    chk("tmo_idle", {30'd0, dut.r_state}, 32'd0);
    chk("tmo_d_err_clear", {31'd0, d_err}, 32'd0);
    tick();
`endif

    // Reset during BUS_D
    if_req = 1'b1; if_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_6000; d_wdata = 32'h0000_1234; d_wstrb = 4'h3;
    tick();
    chk("rb_m_req", {31'd0, m_req}, 32'd1);
    chk("rb_state", {30'd0, dut.r_state}, 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk("rb_m_req_async", {31'd0, m_req}, 32'd0);
    chk("rb_m_we_async", {31'd0, m_we}, 32'd0);
    chk("rb_m_addr_async", m_addr, 32'd0);
    chk("rb_m_wdata_async", m_wdata, 32'd0);
    chk("rb_m_wstrb_async", {28'd0, m_wstrb}, 32'd0);
    chk("rb_if_rdata_async", if_rdata, 32'd0);
    chk("rb_d_rdata_async", d_rdata, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
    chk("rb_state_idle", {30'd0, dut.r_state}, 32'd0);
    chk("rb_dstreak", {28'd0, dut.r_dstreak}, 32'd0);
    chk("rb_m_req_idle", {31'd0, m_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
